// File: rtl/cnn_pkg.sv
// Shared defaults and state encoding for the sram tile reader.
package cnn_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int CNT_WIDTH_DEF  = 16;
  localparam int RD_LATENCY_DEF = 1;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} rd_state_t;

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with a registered head; exposes its fill count for credit accounting.
module stream_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign valid   = count != '0;
  assign full    = count == CW'(DEPTH);
  assign do_pop  = pop && valid;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/sram_tile_reader.sv
// Walks a 2-D tile in row-major order, issues sram reads under a FIFO credit limit,
// and streams the returned words with a last-beat tag.
module sram_tile_reader
  import cnn_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int RD_LATENCY = RD_LATENCY_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [CNT_WIDTH-1:0]  i_row_len,
  input  logic [CNT_WIDTH-1:0]  i_num_rows,
  input  logic [ADDR_WIDTH-1:0] i_row_stride,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_sram_read_en,
  output logic [ADDR_WIDTH-1:0] o_sram_read_addr,
  input  logic [DATA_WIDTH-1:0] i_sram_data,
  input  logic                  i_sram_data_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  rd_state_t             state;
  logic [ADDR_WIDTH-1:0] row_base, addr, stride;
  logic [CNT_WIDTH-1:0]  col, row, row_len, num_rows;
  logic                  zero_tile, busy, done;
  logic [CW-1:0]         inflight, fifo_count;
  logic [RD_LATENCY-1:0] pend_pipe, last_pipe;
  logic                  issue, issue_last, accept, col_end, row_end;
  logic                  pop, fifo_valid, fifo_full;
  logic [DATA_WIDTH:0]   head;

  assign col_end    = col == row_len - CNT_WIDTH'(1);
  assign row_end    = row == num_rows - CNT_WIDTH'(1);
  assign issue      = (state == ISSUE) && !zero_tile &&
                      (({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH));
  assign issue_last = issue && col_end && row_end;
  // Only data belonging to a read issued since the last reset is accepted.
  assign accept     = i_sram_data_valid && pend_pipe[RD_LATENCY-1];
  assign pop        = fifo_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      addr      <= '0;
      row_base  <= '0;
      stride    <= '0;
      col       <= '0;
      row       <= '0;
      row_len   <= '0;
      num_rows  <= '0;
      zero_tile <= 1'b0;
      inflight  <= '0;
      pend_pipe <= '0;
      last_pipe <= '0;
    end else begin
      done      <= 1'b0;
      pend_pipe <= RD_LATENCY'({pend_pipe, issue});
      last_pipe <= RD_LATENCY'({last_pipe, issue_last});
      inflight  <= inflight + CW'(issue) - CW'(accept);
      case (state)
        IDLE: if (i_start) begin
          addr      <= i_base_addr;
          row_base  <= i_base_addr;
          stride    <= i_row_stride;
          row_len   <= i_row_len;
          num_rows  <= i_num_rows;
          col       <= '0;
          row       <= '0;
          zero_tile <= (i_row_len == '0) || (i_num_rows == '0);
          busy      <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: if (zero_tile) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end else if (issue) begin
          if (col_end) begin
            col      <= '0;
            row      <= row + CNT_WIDTH'(1);
            row_base <= row_base + stride;
            addr     <= row_base + stride;
            if (row_end) state <= DRAIN;
          end else begin
            col  <= col + CNT_WIDTH'(1);
            addr <= addr + ADDR_WIDTH'(1);
          end
        end
        DRAIN: if (pop && head[DATA_WIDTH]) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  stream_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst_n (i_nrst),
    .push  (accept),
    .din   ({last_pipe[RD_LATENCY-1], i_sram_data}),
    .pop   (pop),
    .dout  (head),
    .valid (fifo_valid),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // The credit limit makes a return into a full FIFO unreachable.
  always @(posedge i_clk) begin
    if (i_nrst && accept) assert (!fifo_full || pop);
  end

  assign o_busy           = busy;
  assign o_done           = done;
  assign o_sram_read_en   = issue;
  assign o_sram_read_addr = addr;
  assign o_valid          = fifo_valid;
  assign o_data           = fifo_valid ? head[DATA_WIDTH-1:0] : '0;
  assign o_last           = fifo_valid && head[DATA_WIDTH];

endmodule

// File: tb/tb_sram_tile_reader.sv
// Self-checking bench: sram model, stream monitor, row-major reference model.
module tb_sram_tile_reader;

  localparam int AW = 16, DW = 64, CW = 16;

  logic clk = 1'b0, nrst = 1'b0, start = 1'b0, ready = 1'b0;
  logic [AW-1:0] base = '0, stride = '0, read_addr;
  logic [CW-1:0] len = '0, rows = '0;
  logic busy, done, read_en, valid, last;
  logic [DW-1:0] sram_data = '0, data;
  logic sram_valid = 1'b0;

  logic [DW-1:0] mem [0:65535];
  int cyc = 0, checks = 0, errors = 0;
  bit rand_ready = 0, ready_level = 1;

  logic [AW-1:0] rd_q[$], exp_addr[$];
  int rd_cyc[$], bt_cyc[$], done_q[$];
  logic [DW-1:0] bt_data[$];
  bit bt_last[$];
  int busy_cnt = 0, stable_err = 0;
  bit hold = 0;
  logic [DW-1:0] hold_data;
  logic hold_last;

  sram_tile_reader dut (
    .i_clk(clk), .i_nrst(nrst), .i_start(start), .i_base_addr(base),
    .i_row_len(len), .i_num_rows(rows), .i_row_stride(stride),
    .o_busy(busy), .o_done(done), .o_sram_read_en(read_en), .o_sram_read_addr(read_addr),
    .i_sram_data(sram_data), .i_sram_data_valid(sram_valid),
    .o_data(data), .o_valid(valid), .i_ready(ready), .o_last(last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // sram: one cycle read latency, unaffected by the reader's reset
  always @(posedge clk) begin
    sram_valid <= read_en;
    sram_data  <= mem[read_addr];
  end

  always @(posedge clk) begin
    #2;
    ready = rand_ready ? ($urandom_range(0, 9) < 6) : ready_level;
  end

  always @(negedge clk) begin
    if (nrst) begin
      if (read_en) begin rd_q.push_back(read_addr); rd_cyc.push_back(cyc); end
      if (valid && ready) begin
        bt_data.push_back(data); bt_last.push_back(last); bt_cyc.push_back(cyc);
      end
      if (done) done_q.push_back(cyc);
      if (busy) busy_cnt++;
      if (hold && (!valid || data !== hold_data || last !== hold_last)) stable_err++;
      hold = valid && !ready; hold_data = data; hold_last = last;
    end else hold = 0;
  end

  function automatic void model(input logic [AW-1:0] b, input int l, input int r, input logic [AW-1:0] s);
    exp_addr.delete();
    for (int ri = 0; ri < r; ri++)
      for (int ci = 0; ci < l; ci++)
        exp_addr.push_back(AW'(int'(b) + ri * int'(s) + ci));
  endfunction

  task automatic clear_mon();
    rd_q.delete(); rd_cyc.delete(); bt_data.delete(); bt_last.delete(); bt_cyc.delete();
    done_q.delete(); busy_cnt = 0; stable_err = 0;
  endtask

  task automatic start_tile(input logic [AW-1:0] b, input int l, input int r,
                            input logic [AW-1:0] s, output int scyc);
    @(posedge clk); #1;
    base = b; len = CW'(l); rows = CW'(r); stride = s; start = 1'b1; scyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (done_q.size() > 0) ok = 1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, read_en, valid, last} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, read_en, valid, last});
    end
    checks++;
    if (data !== '0 || read_addr !== '0) begin
      errors++; $display("FAIL reset_data: got data=%h addr=%h want 0", data, read_addr);
    end
    @(posedge clk); #1;
    nrst = 1'b1;
  endtask

  task automatic test_basic();
    int s; bit ok;
    for (int i = 0; i < 4; i++) mem[i] = 64'hDEADBEEF00000000 + 64'(i);
    ready_level = 1; clear_mon();
    start_tile(16'd0, 4, 1, 16'd0, s);
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done: timed out, got no done"); end
    checks++;
    if (rd_q.size() != 4) begin errors++; $display("FAIL basic_rd_count: got %0d want 4", rd_q.size()); end
    for (int i = 0; i < rd_q.size() && i < 4; i++) begin
      checks++;
      if (rd_q[i] !== AW'(i)) begin errors++; $display("FAIL basic_addr[%0d]: got %h want %h", i, rd_q[i], i); end
    end
    checks++;
    if (rd_cyc.size() != 4 || rd_cyc[3] - rd_cyc[0] != 3 || rd_cyc[0] != s + 1) begin
      errors++; $display("FAIL basic_rd_timing: first=%0d span=%0d want first=%0d span=3",
                         rd_cyc.size() ? rd_cyc[0] : -1, rd_cyc.size() == 4 ? rd_cyc[3] - rd_cyc[0] : -1, s + 1);
    end
    checks++;
    if (bt_data.size() != 4) begin errors++; $display("FAIL basic_beats: got %0d want 4", bt_data.size()); end
    for (int i = 0; i < bt_data.size() && i < 4; i++) begin
      checks++;
      if (bt_data[i] !== 64'hDEADBEEF00000000 + 64'(i) || bt_last[i] !== (i == 3)) begin
        errors++; $display("FAIL basic_beat[%0d]: got %h last=%0d want %h last=%0d",
                           i, bt_data[i], bt_last[i], 64'hDEADBEEF00000000 + 64'(i), i == 3);
      end
    end
    checks++;
    if (bt_cyc.size() != 4 || rd_cyc.size() == 0 || bt_cyc[0] != rd_cyc[0] + 2) begin
      errors++; $display("FAIL basic_latency: first beat cycle %0d, read cycle %0d, want +2",
                         bt_cyc.size() ? bt_cyc[0] : -1, rd_cyc.size() ? rd_cyc[0] : -1);
    end
    checks++;
    if (done_q.size() != 1 || bt_cyc.size() != 4 || done_q[0] != bt_cyc[3] + 1) begin
      errors++; $display("FAIL basic_done_cycle: got %0d pulses at %0d want 1 at last beat+1",
                         done_q.size(), done_q.size() ? done_q[0] : -1);
    end
  endtask

  task automatic test_rows_stride();
    int s, bad; bit ok;
    logic [AW-1:0] want [6];
    want = '{16'd16, 16'd17, 16'd24, 16'd25, 16'd32, 16'd33};
    ready_level = 1; clear_mon();
    start_tile(16'd16, 2, 3, 16'd8, s);
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stride_done: timed out"); end
    checks++;
    if (rd_q.size() != 6 || bt_data.size() != 6) begin
      errors++; $display("FAIL stride_count: got reads=%0d beats=%0d want 6/6", rd_q.size(), bt_data.size());
    end
    bad = 0;
    for (int i = 0; i < 6 && i < rd_q.size() && i < bt_data.size(); i++)
      if (rd_q[i] !== want[i] || bt_data[i] !== mem[want[i]] || bt_last[i] !== (i == 5)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stride_stream: got %0d bad beats want 0", bad); end
  endtask

  task automatic test_stall();
    int s, bad; bit ok;
    model(16'd0, 8, 1, 16'd0);
    ready_level = 0; clear_mon();
    start_tile(16'd0, 8, 1, 16'd0, s);
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rd_q.size() != 4) begin errors++; $display("FAIL stall_reads: got %0d want 4", rd_q.size()); end
    checks++;
    if (valid !== 1'b1 || data !== mem[0] || last !== 1'b0) begin
      errors++; $display("FAIL stall_head: got v=%0d d=%h l=%0d want v=1 d=%h l=0", valid, data, last, mem[0]);
    end
    ready_level = 1;
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_done: timed out"); end
    checks++;
    if (stable_err != 0) begin errors++; $display("FAIL stall_stable: got %0d changes want 0", stable_err); end
    bad = (rd_q.size() != 8 || bt_data.size() != 8) ? 1 : 0;
    for (int i = 0; i < 8 && i < rd_q.size() && i < bt_data.size(); i++)
      if (rd_q[i] !== exp_addr[i] || bt_data[i] !== mem[exp_addr[i]] || bt_last[i] !== (i == 7)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_stream: got %0d errors want 0", bad); end
  endtask

  task automatic test_wrap();
    int s, bad; bit ok;
    logic [AW-1:0] want [4];
    want = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    ready_level = 1; clear_mon();
    start_tile(16'hFFFE, 4, 1, 16'd0, s);
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_done: timed out"); end
    bad = (rd_q.size() != 4 || bt_data.size() != 4) ? 1 : 0;
    for (int i = 0; i < 4 && i < rd_q.size() && i < bt_data.size(); i++)
      if (rd_q[i] !== want[i] || bt_data[i] !== mem[want[i]]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL wrap_stream: got %0d errors want 0", bad); end
  endtask

  task automatic test_zero_size();
    int s; bit ok;
    for (int k = 0; k < 2; k++) begin
      ready_level = 1; clear_mon();
      start_tile(16'd5, k == 0 ? 0 : 3, k == 0 ? 3 : 0, 16'd1, s);
      wait_done(50, ok);
      repeat (3) @(posedge clk);
      checks++;
      if (!ok || done_q.size() != 1 || done_q[0] != s + 2) begin
        errors++; $display("FAIL zero_done[%0d]: got %0d pulses at %0d want 1 at %0d",
                           k, done_q.size(), done_q.size() ? done_q[0] : -1, s + 2);
      end
      checks++;
      if (rd_q.size() != 0 || busy_cnt != 1) begin
        errors++; $display("FAIL zero_reads[%0d]: got reads=%0d busy=%0d want 0/1", k, rd_q.size(), busy_cnt);
      end
    end
  endtask

  task automatic test_ignore_start();
    int s, bad; bit ok;
    ready_level = 1; clear_mon();
    start_tile(16'd0, 4, 1, 16'd0, s);
    start = 1'b1; base = 16'd100; len = 16'd2; rows = 16'd1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(200, ok);
    repeat (10) @(posedge clk);
    bad = (rd_q.size() != 4) ? 1 : 0;
    for (int i = 0; i < rd_q.size() && i < 4; i++) if (rd_q[i] !== AW'(i)) bad++;
    checks++;
    if (!ok || bad != 0 || done_q.size() != 1) begin
      errors++; $display("FAIL ignore_start: got reads=%0d done=%0d bad=%0d want 4/1/0", rd_q.size(), done_q.size(), bad);
    end
  endtask

  task automatic test_reset_mid();
    int s, bad; bit ok;
    ready_level = 1; clear_mon();
    start_tile(16'd0, 8, 2, 16'd16, s);
    repeat (3) @(posedge clk);
    #1; nrst = 1'b0;
    @(posedge clk); #1; nrst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, read_en, valid, last} !== 5'b0 || data !== '0 || read_addr !== '0) begin
      errors++; $display("FAIL midreset_outs: got ctrl=%b data=%h addr=%h want 0",
                         {busy, done, read_en, valid, last}, data, read_addr);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL midreset_drop: got valid=%0d want 0", valid); end
    clear_mon();
    model(16'd40, 3, 2, 16'd5);
    start_tile(16'd40, 3, 2, 16'd5, s);
    wait_done(200, ok);
    bad = (rd_q.size() != 6 || bt_data.size() != 6) ? 1 : 0;
    for (int i = 0; i < 6 && i < rd_q.size() && i < bt_data.size(); i++)
      if (rd_q[i] !== exp_addr[i] || bt_data[i] !== mem[exp_addr[i]] || bt_last[i] !== (i == 5)) bad++;
    checks++;
    if (!ok || bad != 0 || done_q.size() != 1) begin
      errors++; $display("FAIL midreset_fresh: got bad=%0d done=%0d want 0/1", bad, done_q.size());
    end
  endtask

  task automatic test_random();
    int s, bad, l, r; bit ok;
    logic [AW-1:0] b, st;
    rand_ready = 1;
    for (int t = 0; t < 8; t++) begin
      b = AW'($urandom); st = AW'($urandom_range(0, 40)); l = $urandom_range(1, 6); r = $urandom_range(1, 3);
      model(b, l, r, st);
      clear_mon();
      start_tile(b, l, r, st, s);
      wait_done(400, ok);
      bad = (rd_q.size() != exp_addr.size() || bt_data.size() != exp_addr.size()) ? 1 : 0;
      for (int i = 0; i < exp_addr.size() && i < rd_q.size() && i < bt_data.size(); i++)
        if (rd_q[i] !== exp_addr[i] || bt_data[i] !== mem[exp_addr[i]] ||
            bt_last[i] !== (i == exp_addr.size() - 1)) bad++;
      checks++;
      if (!ok || bad != 0 || done_q.size() != 1 || stable_err != 0) begin
        errors++; $display("FAIL random[%0d]: got bad=%0d done=%0d unstable=%0d want 0/1/0 (base=%h len=%0d rows=%0d stride=%0d)",
                           t, bad, done_q.size(), stable_err, b, l, r, st);
      end
    end
    rand_ready = 0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = {$urandom, $urandom};
    test_reset();
    test_basic();
    test_rows_stride();
    test_stall();
    test_wrap();
    test_zero_size();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
